m_nhart_mem_arbiter: RTL and testbench

- Shared-DRAM arbiter and LR/SC reservation monitor for an NHART-wide multi-hart SoC.
- Replaces the fixed two-hart grant word and the per-pair "other hart" reservation signals with one parametrised block.
- Each hart's MMU issues a DRAM request. The block grants one hart at a time in round-robin order and forwards the request to the single DRAM port.
- It also tracks one reservation per hart, so SC success and failure are decided centrally.

---
 rtl/m_nhart_mem_arbiter_if.sv | 54 +++++
 rtl/m_nhart_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 tb/tb_m_nhart_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m_nhart_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// m_nhart_mem_arbiter_if
// Bundles the per-hart request channels and the single DRAM port of the
// shared-memory arbiter.
//   slave  : arbiter side. It takes the hart requests and DRAM read data, and
//            drives the grants, completions, reservation flags and DRAM command.
//   master : environment side. It holds the harts' MMUs and the DRAM device.
// Per-hart vectors are packed: hart h uses bit h, [h*AW +: AW],
// [h*DW +: DW] and [h*3 +: 3].
// ---------------------------------------------------------------------------
interface m_nhart_mem_arbiter_if #(
    parameter int NHART = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    // hart request channels
    logic [NHART-1:0]    w_req_le;
    logic [NHART-1:0]    w_req_we;
    logic [NHART-1:0]    w_req_lr;
    logic [NHART-1:0]    w_req_sc;
    logic [NHART*AW-1:0] w_req_addr;
    logic [NHART*DW-1:0] w_req_wdata;
    logic [NHART*3-1:0]  w_req_ctrl;
    // arbiter responses
    logic [NHART-1:0]    w_grant;
    logic [NHART-1:0]    w_req_done;
    logic [DW-1:0]       w_rdata;
    logic                w_sc_fail;
    logic [NHART-1:0]    w_resv_valid;
    // DRAM port
    logic [AW-1:0]       w_dram_addr;
    logic [DW-1:0]       w_dram_wdata;
    logic [2:0]          w_dram_ctrl;
    logic                w_dram_le;
    logic                w_dram_we_t;
    logic [DW-1:0]       w_dram_odata;
    logic                w_dram_busy;

    modport slave (
        input  w_req_le, w_req_we, w_req_lr, w_req_sc,
        input  w_req_addr, w_req_wdata, w_req_ctrl,
        input  w_dram_odata, w_dram_busy,
        output w_grant, w_req_done, w_rdata, w_sc_fail, w_resv_valid,
        output w_dram_addr, w_dram_wdata, w_dram_ctrl, w_dram_le, w_dram_we_t
    );

    modport master (
        output w_req_le, w_req_we, w_req_lr, w_req_sc,
        output w_req_addr, w_req_wdata, w_req_ctrl,
        output w_dram_odata, w_dram_busy,
        input  w_grant, w_req_done, w_rdata, w_sc_fail, w_resv_valid,
        input  w_dram_addr, w_dram_wdata, w_dram_ctrl, w_dram_le, w_dram_we_t
    );
endinterface

// File: rtl/m_nhart_mem_arbiter.sv
// ---------------------------------------------------------------------------
// m_nhart_mem_arbiter
// Round-robin arbiter that shares one DRAM port between NHART harts. It also
// keeps one LR/SC reservation per hart, so SC pass/fail is decided centrally.
// Ports:
//   CLK    : clock
//   RST_X  : asynchronous active-low reset; it aborts any transaction in flight
//   bus    : m_nhart_mem_arbiter_if.slave, with the hart request channels
//            (le/we/lr/sc/addr/wdata/ctrl), grant/done/rdata/sc_fail,
//            the reservation flags and the DRAM command/response port
// Every output is a register. The FSM computes each output's value for the
// next state, so strobes and done line up exactly with ISSUE and DONE.
// ---------------------------------------------------------------------------
module m_nhart_mem_arbiter #(
    parameter int NHART = 2,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int GRAN  = 2
) (
    input  logic                  CLK,
    input  logic                  RST_X,
    m_nhart_mem_arbiter_if.slave  bus
);
    localparam int IW = (NHART > 1) ? $clog2(NHART) : 1;
    localparam int RW = AW - GRAN;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Reservation granule index of a byte address.
    function automatic logic [RW-1:0] granule(input logic [AW-1:0] a);
        return a[AW-1:GRAN];
    endfunction

    // One-hot vector for a hart index.
    function automatic logic [NHART-1:0] onehot(input logic [IW-1:0] i);
        logic [NHART-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // FSM and output registers
    state_t            state_r;
    state_t            state_nxt_s;
    logic [NHART-1:0]  grant_r, grant_nxt_s;
    logic [NHART-1:0]  done_r, done_nxt_s;
    logic              le_r, le_nxt_s;
    logic              we_r, we_nxt_s;
    logic              sc_fail_r, sc_fail_nxt_s;
    logic [DW-1:0]     rdata_r, rdata_nxt_s;
    logic              latch_s;

    // latched transaction
    logic [IW-1:0]     idx_r;
    logic [AW-1:0]     addr_r;
    logic [DW-1:0]     wdata_r;
    logic [2:0]        ctrl_r;
    logic              op_load_r, op_lr_r, op_store_r, op_sc_r, sc_pass_r;

    // arbitration history
    logic [IW-1:0]     last_r;
    logic [NHART-1:0]  mask_r;

    // reservations
    logic [NHART-1:0]  resv_valid_r;
    logic [RW-1:0]     resv_addr_r [NHART];

    // selection
    logic [NHART-1:0]  req_s;
    logic              pick_found_s;
    logic [IW-1:0]     pick_idx_s;
    logic              sel_le_s, sel_we_s, sel_lr_s, sel_sc_s, sel_load_s, sel_pass_s;
    logic [AW-1:0]     sel_addr_s;
    logic [DW-1:0]     sel_wdata_s;
    logic [2:0]        sel_ctrl_s;

    // The previous owner is masked during the first IDLE cycle after its
    // done, because its request level may still be up in that cycle.
    assign req_s = (bus.w_req_le | bus.w_req_we) & ~mask_r;

    // Round-robin pick: the first requester after last_r, wrapping modulo NHART.
    always_comb begin
        int cand_k;
        cand_k       = 0;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        for (int i = 1; i <= NHART; i++) begin
            cand_k = int'(last_r) + i;
            cand_k = (cand_k >= NHART) ? (cand_k - NHART) : cand_k;
            if (!pick_found_s && req_s[IW'(cand_k)]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = IW'(cand_k);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    assign sel_le_s    = bus.w_req_le[pick_idx_s];
    assign sel_we_s    = bus.w_req_we[pick_idx_s];
    assign sel_lr_s    = bus.w_req_lr[pick_idx_s];
    assign sel_sc_s    = bus.w_req_sc[pick_idx_s];
    assign sel_addr_s  = bus.w_req_addr[int'(pick_idx_s)*AW +: AW];
    assign sel_wdata_s = bus.w_req_wdata[int'(pick_idx_s)*DW +: DW];
    assign sel_ctrl_s  = bus.w_req_ctrl[int'(pick_idx_s)*3 +: 3];
    // le together with we counts as a store.
    assign sel_load_s  = sel_le_s & ~sel_we_s;
    // Reservations only change in DONE, so they can be checked at selection time.
    assign sel_pass_s  = resv_valid_r[pick_idx_s] &&
                         (resv_addr_r[pick_idx_s] == granule(sel_addr_s));

    // Next-state and next-output logic.
    always_comb begin
        state_nxt_s   = state_r;
        grant_nxt_s   = grant_r;
        done_nxt_s    = '0;
        le_nxt_s      = 1'b0;
        we_nxt_s      = 1'b0;
        sc_fail_nxt_s = 1'b0;
        rdata_nxt_s   = rdata_r;
        latch_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    state_nxt_s = ISSUE;
                    latch_s     = 1'b1;
                    grant_nxt_s = onehot(pick_idx_s);
                    le_nxt_s    = sel_load_s;
                    // A failing SC never reaches the DRAM.
                    we_nxt_s    = sel_we_s & (~sel_sc_s | sel_pass_s);
                end else begin
                    state_nxt_s = IDLE;
                    grant_nxt_s = '0;
                end
            end
            ISSUE: begin
                if (op_sc_r && !sc_pass_r) begin
                    state_nxt_s   = DONE;
                    done_nxt_s    = grant_r;
                    sc_fail_nxt_s = 1'b1;
                end else begin
                    state_nxt_s   = WAIT;
                end
            end
            WAIT: begin
                if (!bus.w_dram_busy) begin
                    state_nxt_s = DONE;
                    done_nxt_s  = grant_r;
                    if (op_load_r) begin
                        rdata_nxt_s = bus.w_dram_odata;
                    end else begin
                        rdata_nxt_s = rdata_r;
                    end
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
                grant_nxt_s = '0;
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = '0;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_r   <= IDLE;
            grant_r   <= '0;
            done_r    <= '0;
            le_r      <= 1'b0;
            we_r      <= 1'b0;
            sc_fail_r <= 1'b0;
            rdata_r   <= '0;
        end else begin
            state_r   <= state_nxt_s;
            grant_r   <= grant_nxt_s;
            done_r    <= done_nxt_s;
            le_r      <= le_nxt_s;
            we_r      <= we_nxt_s;
            sc_fail_r <= sc_fail_nxt_s;
            rdata_r   <= rdata_nxt_s;
        end
    end

    // Transaction latch. The address, data and control stay stable until the next grant.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            idx_r      <= '0;
            addr_r     <= '0;
            wdata_r    <= '0;
            ctrl_r     <= 3'd0;
            op_load_r  <= 1'b0;
            op_lr_r    <= 1'b0;
            op_store_r <= 1'b0;
            op_sc_r    <= 1'b0;
            sc_pass_r  <= 1'b0;
        end else if (latch_s) begin
            idx_r      <= pick_idx_s;
            addr_r     <= sel_addr_s;
            wdata_r    <= sel_wdata_s;
            ctrl_r     <= sel_ctrl_s;
            op_load_r  <= sel_load_s;
            op_lr_r    <= sel_load_s & sel_lr_s;
            op_store_r <= sel_we_s;
            op_sc_r    <= sel_we_s & sel_sc_s;
            sc_pass_r  <= sel_pass_s;
        end
    end

    // Round-robin pointer and the one-cycle mask on the previous owner.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            last_r <= IW'(NHART - 1);
            mask_r <= '0;
        end else if (state_r == DONE) begin
            last_r <= idx_r;
            mask_r <= grant_r;
        end else begin
            mask_r <= '0;
        end
    end

    // Reservation updates when a transaction completes.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            resv_valid_r <= '0;
            for (int k = 0; k < NHART; k++) begin
                resv_addr_r[k] <= '0;
            end
        end else if (state_r == DONE) begin
            for (int k = 0; k < NHART; k++) begin
                if (op_lr_r && (int'(idx_r) == k)) begin
                    resv_valid_r[k] <= 1'b1;
                    resv_addr_r[k]  <= granule(addr_r);
                end else if (op_store_r && (!op_sc_r || sc_pass_r) &&
                             (resv_addr_r[k] == granule(addr_r))) begin
                    resv_valid_r[k] <= 1'b0;
                end
                // Any SC, pass or fail, consumes the owner's reservation.
                if (op_sc_r && (int'(idx_r) == k)) begin
                    resv_valid_r[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.w_grant      = grant_r;
    assign bus.w_req_done   = done_r;
    assign bus.w_rdata      = rdata_r;
    assign bus.w_sc_fail    = sc_fail_r;
    assign bus.w_resv_valid = resv_valid_r;
    assign bus.w_dram_addr  = addr_r;
    assign bus.w_dram_wdata = wdata_r;
    assign bus.w_dram_ctrl  = ctrl_r;
    assign bus.w_dram_le    = le_r;
    assign bus.w_dram_we_t  = we_r;
endmodule

// File: tb/tb_m_nhart_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_m_nhart_mem_arbiter
// Directed and random stimulus for a 4-hart arbiter. A transaction-level
// reference model predicts the round-robin owner, the latency, the strobe
// counts, the read data, SC pass/fail and the reservation flags.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_m_nhart_mem_arbiter;
    localparam int NH   = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int GRAN = 2;

    logic clk = 1'b0;
    logic rst_x;
    always #5 clk = ~clk;

    m_nhart_mem_arbiter_if #(.NHART(NH), .AW(AW), .DW(DW)) bus ();
    m_nhart_mem_arbiter #(.NHART(NH), .AW(AW), .DW(DW), .GRAN(GRAN)) dut (
        .CLK   (clk),
        .RST_X (rst_x),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // hart request state
    logic [NH-1:0] p_le, p_we, p_lr, p_sc, rep;
    logic [AW-1:0] p_addr  [NH];
    logic [DW-1:0] p_wdata [NH];
    logic [2:0]    p_ctrl  [NH];

    // reference model
    logic [NH-1:0]      m_rv;
    logic [AW-GRAN-1:0] m_ra [NH];
    int                 m_last;

    // current transaction
    int owner, t_start, t_stall, le_cnt, we_cnt;
    logic t_load, t_lr, t_store, t_sc, t_scfail;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, t_odata, fixed_odata;
    logic [2:0]    t_ctrl;
    int   excl_next, stall_left, stall_n, n_done, last_lat;
    bit   rand_stall, chk_resv_pend;
    logic last_scfail;
    int   grant_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NH-1:0] onehot(input int p);
        logic [NH-1:0] v;
        v = '0;
        if (p >= 0) v[p] = 1'b1;
        return v;
    endfunction

    // The first candidate after 'last' in circular order.
    function automatic int rr_pick(input logic [NH-1:0] cand, input int last);
        for (int i = 1; i <= NH; i++) begin
            if (cand[(last + i) % NH]) return (last + i) % NH;
        end
        return -1;
    endfunction

    function automatic int log_at(input int i);
        if (i < grant_log.size()) return grant_log[i];
        return -1;
    endfunction

    task automatic drive_reqs();
        for (int h = 0; h < NH; h++) begin
            bus.w_req_le[h] = p_le[h];
            bus.w_req_we[h] = p_we[h];
            bus.w_req_lr[h] = p_lr[h];
            bus.w_req_sc[h] = p_sc[h];
            bus.w_req_addr[h*AW +: AW]  = p_addr[h];
            bus.w_req_wdata[h*DW +: DW] = p_wdata[h];
            bus.w_req_ctrl[h*3 +: 3]    = p_ctrl[h];
        end
    endtask

    task automatic set_req(input int h, input logic le, input logic we, input logic lr,
                           input logic sc, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_le[h] = le; p_we[h] = we; p_lr[h] = lr; p_sc[h] = sc;
        p_addr[h] = a; p_wdata[h] = d; p_ctrl[h] = 3'($urandom_range(0, 7));
        drive_reqs();
    endtask

    task automatic model_reset();
        owner = -1; m_last = NH - 1; m_rv = '0; excl_next = -1;
        stall_left = 0; chk_resv_pend = 1'b0;
        for (int h = 0; h < NH; h++) m_ra[h] = '0;
        p_le = '0; p_we = '0; p_lr = '0; p_sc = '0; rep = '0;
        bus.w_dram_busy = 1'b0;
        drive_reqs();
    endtask

    // One clock: sample #1 after the edge, check against the model, then update stimulus.
    task automatic tick();
        logic [NH-1:0] cand;
        logic [AW-GRAN-1:0] g;
        int p, lat, exp_lat;
        cand = bus.w_req_le | bus.w_req_we;
        if (excl_next >= 0) cand[excl_next] = 1'b0;
        @(posedge clk); #1;
        cyc++;
        excl_next = -1;
        if (stall_left > 0) begin
            bus.w_dram_busy = 1'b1;
            stall_left--;
        end else begin
            bus.w_dram_busy = 1'b0;
        end
        if (chk_resv_pend) begin
            chk("resv_valid", bus.w_resv_valid, m_rv);
            chk_resv_pend = 1'b0;
        end
        if (owner < 0 && bus.w_grant != '0) begin
            p = rr_pick(cand, m_last);
            chk("grant_pick", bus.w_grant, onehot(p));
            owner = p;
            if (p >= 0) begin
                grant_log.push_back(p);
                t_start = cyc; le_cnt = 0; we_cnt = 0; t_stall = 0;
                t_addr = p_addr[p]; t_wdata = p_wdata[p]; t_ctrl = p_ctrl[p];
                t_store  = p_we[p];
                t_load   = p_le[p] & ~p_we[p];
                t_lr     = t_load & p_lr[p];
                t_sc     = p_we[p] & p_sc[p];
                t_scfail = t_sc && !(m_rv[p] && (m_ra[p] == t_addr[AW-1:GRAN]));
            end
        end
        if (owner >= 0) begin
            chk("grant_hold", bus.w_grant, onehot(owner));
            chk("dram_addr", bus.w_dram_addr, t_addr);
            if (bus.w_dram_le || bus.w_dram_we_t) begin
                le_cnt += int'(bus.w_dram_le);
                we_cnt += int'(bus.w_dram_we_t);
                chk("dram_wdata", bus.w_dram_wdata, t_wdata);
                chk("dram_ctrl", bus.w_dram_ctrl, t_ctrl);
                t_stall = rand_stall ? int'($urandom_range(0, 3)) : stall_n;
                stall_left = t_stall;
                t_odata = rand_stall ? DW'($urandom) : fixed_odata;
                bus.w_dram_odata = t_odata;
            end
            if (bus.w_req_done != '0) begin
                n_done++;
                chk("done_owner", bus.w_req_done, onehot(owner));
                lat = cyc - t_start + 1;
                exp_lat = t_scfail ? 2 : 3 + t_stall;
                last_lat = lat;
                last_scfail = bus.w_sc_fail;
                chk("latency", lat, exp_lat);
                chk("sc_fail", bus.w_sc_fail, t_scfail);
                chk("le_strobes", le_cnt, t_load ? 1 : 0);
                chk("we_strobes", we_cnt, (t_store && !t_scfail) ? 1 : 0);
                if (t_load) chk("rdata", bus.w_rdata, t_odata);
                g = t_addr[AW-1:GRAN];
                if (t_lr) begin
                    m_rv[owner] = 1'b1;
                    m_ra[owner] = g;
                end
                if (t_store && !t_scfail) begin
                    for (int k = 0; k < NH; k++) if (m_ra[k] == g) m_rv[k] = 1'b0;
                end
                if (t_sc) m_rv[owner] = 1'b0;
                chk_resv_pend = 1'b1;
                m_last = owner;
                excl_next = owner;
                if (!rep[owner]) begin
                    p_le[owner] = 1'b0;
                    p_we[owner] = 1'b0;
                end
                owner = -1;
                drive_reqs();
            end
        end else begin
            chk("idle_quiet", {bus.w_req_done, bus.w_dram_le, bus.w_dram_we_t, bus.w_sc_fail}, 64'd0);
        end
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while (((p_le | p_we) != '0 || owner >= 0) && n < max) begin
            tick();
            n++;
        end
        chk("drain_bound", (n < max) ? 1 : 0, 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_x = 1'b0;
        rand_stall = 1'b0; stall_n = 0; fixed_odata = 32'h1111_0000;
        n_done = 0; last_lat = 0; last_scfail = 1'b0;
        for (int h = 0; h < NH; h++) begin
            p_addr[h] = '0; p_wdata[h] = '0; p_ctrl[h] = 3'd0;
        end
        bus.w_dram_odata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // reset state
        chk("rst_grant", bus.w_grant, 64'd0);
        chk("rst_done", bus.w_req_done, 64'd0);
        chk("rst_strobes", {bus.w_dram_le, bus.w_dram_we_t, bus.w_sc_fail}, 64'd0);
        chk("rst_resv", bus.w_resv_valid, 64'd0);
        chk("rst_dram_addr", bus.w_dram_addr, 64'd0);
        chk("rst_rdata", bus.w_rdata, 64'd0);
        rst_x = 1'b1;

        // simultaneous loads from harts 0, 2, 3
        grant_log.delete(); n_done = 0;
        set_req(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0100, 32'h0);
        set_req(2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0200, 32'h0);
        set_req(3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0300, 32'h0);
        drain(60);
        chk("simul_count", grant_log.size(), 3);
        chk("simul_order0", log_at(0), 0);
        chk("simul_order1", log_at(1), 2);
        chk("simul_order2", log_at(2), 3);
        chk("simul_dones", n_done, 3);

        // load with a 5-cycle DRAM stall
        fixed_odata = 32'hDEAD_BEEF; stall_n = 5;
        set_req(1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_1000, 32'h0);
        drain(60);
        chk("stall_latency", last_lat, 8);
        stall_n = 0;

        // LR then SC succeeds
        set_req(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_2004, 32'h0);
        drain(40);
        chk("lr_resv0", bus.w_resv_valid[0], 1);
        set_req(0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_2004, 32'h1);
        drain(40);
        chk("sc_ok", last_scfail, 0);
        chk("sc_resv0_clear", bus.w_resv_valid[0], 0);

        // reservation broken by a store to the same word
        set_req(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_2004, 32'h0);
        drain(40);
        set_req(1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_2006, 32'h55);
        drain(40);
        set_req(0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_2004, 32'h1);
        drain(40);
        chk("sc_broken_fail", last_scfail, 1);
        chk("sc_broken_lat", last_lat, 2);
        // a store to the next word leaves the reservation intact
        set_req(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_2004, 32'h0);
        drain(40);
        set_req(1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_2008, 32'h66);
        drain(40);
        set_req(0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_2004, 32'h1);
        drain(40);
        chk("sc_other_word_ok", last_scfail, 0);

        // hart0 requests continuously while hart1 requests once
        grant_log.delete();
        rep[0] = 1'b1;
        set_req(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_4000, 32'h0);
        n = 0;
        while (grant_log.size() < 1 && n < 10) begin tick(); n++; end
        set_req(1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_4010, 32'h77);
        n = 0;
        while (p_we[1] && n < 40) begin tick(); n++; end
        chk("starve_bound", (n < 40) ? 1 : 0, 1);
        rep[0] = 1'b0;
        drain(40);
        chk("starve_first", log_at(0), 0);
        chk("starve_next", log_at(1), 1);

        // random traffic on a small address pool so reservations interact
        rand_stall = 1'b1;
        for (int it = 0; it < 300; it++) begin
            for (int h = 0; h < NH; h++) begin
                if (!p_le[h] && !p_we[h] && $urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 5))
                        0: set_req(h, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_3000 + 32'($urandom_range(0, 15)), $urandom);
                        1: set_req(h, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_3000 + 32'($urandom_range(0, 15)), $urandom);
                        2: set_req(h, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_3000 + 32'($urandom_range(0, 15)), $urandom);
                        3: set_req(h, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_3000 + 32'($urandom_range(0, 15)), $urandom);
                        4: set_req(h, 1'b1, 1'b1, 1'b1, 1'b0, 32'h8000_3000 + 32'($urandom_range(0, 15)), $urandom);
                        default: set_req(h, 1'b0, 1'b1, 1'b1, 1'b0, 32'h8000_3000 + 32'($urandom_range(0, 15)), $urandom);
                    endcase
                end
            end
            tick();
        end
        drain(300);
        rand_stall = 1'b0;

        // reset in the middle of a stalled load, with a reservation held
        set_req(3, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_5000, 32'h0);
        drain(40);
        chk("pre_rst_resv3", bus.w_resv_valid[3], 1);
        stall_n = 6;
        set_req(2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_6000, 32'h0);
        n = 0;
        while (!(owner == 2 && le_cnt == 1) && n < 10) begin tick(); n++; end
        chk("pre_rst_issue", (n < 10) ? 1 : 0, 1);
        tick(); tick();
        chk("pre_rst_busy", bus.w_dram_busy, 1);
        #2 rst_x = 1'b0;
        #1;
        chk("mid_rst_grant", bus.w_grant, 64'd0);
        chk("mid_rst_strobes", {bus.w_dram_le, bus.w_dram_we_t}, 64'd0);
        chk("mid_rst_done", bus.w_req_done, 64'd0);
        chk("mid_rst_resv", bus.w_resv_valid, 64'd0);
        model_reset();
        stall_n = 0;
        @(posedge clk); #1;
        chk("held_rst_done", bus.w_req_done, 64'd0);
        rst_x = 1'b1;
        grant_log.delete();
        set_req(1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_7100, 32'h0);
        set_req(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_7000, 32'h0);
        set_req(2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_7200, 32'h0);
        drain(60);
        chk("post_rst_first", log_at(0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
